// File: rtl/tdm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_pkg: shared types and the select-decode helper for the TDM       |
// | frame collector.                                                      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package tdm_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic [0:0] {
    SYNC    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  typedef struct packed {
    logic    ok;
    ch_idx_t idx;
  } ch_dec_t;

  // ok is low for an all-zero or multi-hot select vector
  function automatic ch_dec_t onehot_to_idx(input logic [NUM_CH-1:0] sel);
    ch_dec_t r;
    r.ok  = 1'b1;
    r.idx = 2'd0;
    case (sel)
      4'b0001: r.idx = 2'd0;
      4'b0010: r.idx = 2'd1;
      4'b0100: r.idx = 2'd2;
      4'b1000: r.idx = 2'd3;
      default: r.ok  = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_settle_gate.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_settle_gate: tracks the mux select vector and flags when ADC      |
// | samples have settled long enough after a select change to be used.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tdm_settle_gate import tdm_pkg::*; #(
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [NUM_CH-1:0] i_sel,
  output logic              o_elig
);

  localparam logic [3:0] c_SETTLE = 4'(SETTLE_CYC);

  logic [NUM_CH-1:0] r_sel;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              w_chg;

  assign w_chg = (i_sel != r_sel);

  // The count seen by the current cycle already includes this cycle's reload
  // or decrement, so a change cycle is never eligible unless SETTLE_CYC is 0.
  always_comb begin
    w_cnt_nxt = 4'd0;
    if (w_chg)
      w_cnt_nxt = c_SETTLE;
    else if (r_cnt != 4'd0)
      w_cnt_nxt = r_cnt - 4'd1;
  end

  assign o_elig = (w_cnt_nxt == 4'd0);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_sel <= '0;
      r_cnt <= c_SETTLE;
    end else begin
      r_sel <= i_sel;
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tdm_frame_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_frame_collector: gathers settled, channel-tagged ADC samples into |
// | ordered 4-channel frames and offers them on a valid/ready port.       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tdm_frame_collector import tdm_pkg::*; #(
  parameter int DATA_W     = 12,
  parameter int SETTLE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  CH1,
  input  logic                  CH2,
  input  logic                  CH3,
  input  logic                  CH4,
  input  logic                  smp_valid,
  input  logic [DATA_W-1:0]     smp_data,
  output logic                  frm_valid,
  input  logic                  frm_ready,
  output logic [4*DATA_W-1:0]   frm_data,
  output logic                  sel_err,
  output logic                  seq_err,
  output logic                  ovf
);

  logic [NUM_CH-1:0] w_sel;
  ch_dec_t           w_dec;
  logic              w_elig;
  logic              w_take;
  logic              w_bad_sel;

  state_t            r_state;
  state_t            w_state_nxt;
  ch_idx_t           r_exp;
  ch_idx_t           w_exp_nxt;

  logic              w_store;
  logic              w_complete;
  logic              w_seq_fault;
  logic              w_load;

  logic [DATA_W-1:0]   r_slot0;
  logic [DATA_W-1:0]   r_slot1;
  logic [DATA_W-1:0]   r_slot2;
  logic                r_frm_valid;
  logic [4*DATA_W-1:0] r_frm_data;
  logic                r_sel_err;
  logic                r_seq_err;
  logic                r_ovf;

  assign w_sel = {CH4, CH3, CH2, CH1};
  assign w_dec = onehot_to_idx(w_sel);

  tdm_settle_gate #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_settle (
    .clk    (clk),
    .RST    (RST),
    .i_sel  (w_sel),
    .o_elig (w_elig)
  );

  assign w_take    = smp_valid & w_elig & w_dec.ok;
  assign w_bad_sel = smp_valid & ~w_dec.ok;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state <= SYNC;
      r_exp   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_exp   <= w_exp_nxt;
    end
  end

  // A repeat of the channel just stored (idx == exp-1) is silently ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    if (w_bad_sel) begin
      w_state_nxt = SYNC;
      w_exp_nxt   = 2'd0;
    end else if (w_take) begin
      case (r_state)
        SYNC: begin
          if (w_dec.idx == 2'd0) begin
            w_state_nxt = COLLECT;
            w_exp_nxt   = 2'd1;
          end
        end
        COLLECT: begin
          if (w_dec.idx == r_exp) begin
            if (w_dec.idx == 2'd3) begin
              w_state_nxt = SYNC;
              w_exp_nxt   = 2'd0;
            end else begin
              w_exp_nxt = r_exp + 2'd1;
            end
          end else if (w_dec.idx != r_exp - 2'd1) begin
            if (w_dec.idx == 2'd0) begin
              w_exp_nxt = 2'd1;
            end else begin
              w_state_nxt = SYNC;
              w_exp_nxt   = 2'd0;
            end
          end
        end
        default: begin
          w_state_nxt = SYNC;
          w_exp_nxt   = 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    w_store     = 1'b0;
    w_complete  = 1'b0;
    w_seq_fault = 1'b0;
    if (w_take) begin
      if (r_state == SYNC) begin
        w_store = (w_dec.idx == 2'd0);
      end else if (w_dec.idx == r_exp) begin
        w_store    = 1'b1;
        w_complete = (w_dec.idx == 2'd3);
      end else if (w_dec.idx != r_exp - 2'd1) begin
        w_seq_fault = 1'b1;
        w_store     = (w_dec.idx == 2'd0);
      end
    end
  end

  assign w_load = w_complete & (~r_frm_valid | frm_ready);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_slot2 <= '0;
    end else if (w_store) begin
      case (w_dec.idx)
        2'd0:    r_slot0 <= smp_data;
        2'd1:    r_slot1 <= smp_data;
        2'd2:    r_slot2 <= smp_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_frm_valid <= 1'b0;
      r_frm_data  <= '0;
      r_sel_err   <= 1'b0;
      r_seq_err   <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_load) begin
        r_frm_valid <= 1'b1;
        r_frm_data  <= {smp_data, r_slot2, r_slot1, r_slot0};
      end else if (r_frm_valid & frm_ready) begin
        r_frm_valid <= 1'b0;
      end
      if (w_complete & ~w_load) r_ovf <= 1'b1;
      if (w_bad_sel)            r_sel_err <= 1'b1;
      if (w_seq_fault)          r_seq_err <= 1'b1;
    end
  end

  assign frm_valid = r_frm_valid;
  assign frm_data  = r_frm_data;
  assign sel_err   = r_sel_err;
  assign seq_err   = r_seq_err;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_tdm_frame_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tdm_frame_collector: directed self-checking bench for the TDM     |
// | frame collector (DATA_W=12, SETTLE_CYC=2).                            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_tdm_frame_collector;

  localparam int DATA_W = 12;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        ch1 = 1'b0, ch2 = 1'b0, ch3 = 1'b0, ch4 = 1'b0;
  logic        smp_valid = 1'b0;
  logic [11:0] smp_data = '0;
  logic        frm_valid;
  logic        frm_ready = 1'b1;
  logic [47:0] frm_data;
  logic        sel_err, seq_err, ovf;

  int n_chk  = 0;
  int n_fail = 0;
  int hs_cnt = 0;

  tdm_frame_collector #(.DATA_W(DATA_W), .SETTLE_CYC(2)) dut (
    .clk       (clk),
    .RST       (RST),
    .CH1       (ch1),
    .CH2       (ch2),
    .CH3       (ch3),
    .CH4       (ch4),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .frm_valid (frm_valid),
    .frm_ready (frm_ready),
    .frm_data  (frm_data),
    .sel_err   (sel_err),
    .seq_err   (seq_err),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frm_valid && frm_ready) hs_cnt++;

  // One select slot of len cycles; samples on cycles flagged in smask.
  // Reports the first cycle (observed at negedge) where frm_valid was high.
  task automatic slot(input logic [3:0] sel, input logic [11:0] d, input logic [15:0] smask,
                      input int len, output int v_at, output logic [47:0] v_data);
    logic first;
    first  = 1'b1;
    v_at   = -1;
    v_data = '0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (frm_valid === 1'b1 && v_at < 0) begin
        v_at   = c;
        v_data = frm_data;
      end
      {ch4, ch3, ch2, ch1} = sel;
      smp_valid = smask[c];
      smp_data  = first ? d : (d | 12'h800);
      if (smask[c]) first = 1'b0;
    end
  endtask

  // CH1..CH4 pass with data base+1..base+4; frame info from the CH4 slot.
  task automatic pass(input logic [11:0] base, input logic [15:0] smask,
                      output int v_at, output logic [47:0] v_data);
    int          va;
    logic [47:0] vd;
    slot(4'b0001, base + 12'd1, smask, 8, va, vd);
    slot(4'b0010, base + 12'd2, smask, 8, va, vd);
    slot(4'b0100, base + 12'd3, smask, 8, va, vd);
    slot(4'b1000, base + 12'd4, smask, 8, v_at, v_data);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_chk++; if (frm_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", frm_valid); end
    n_chk++; if (frm_data !== 48'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", frm_data); end
    n_chk++; if ({sel_err, seq_err, ovf} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {sel_err, seq_err, ovf}); end
    RST = 1'b0;
  endtask

  task automatic test_nominal;
    int va; logic [47:0] vd; int h0;
    h0 = hs_cnt;
    slot(4'b1000, 12'h004, 16'h0010, 8, va, vd);
    n_chk++; if (va !== -1) begin n_fail++; $display("FAIL nom_lead_ch4: got frame at %0d expected none", va); end
    pass(12'h000, 16'h0010, va, vd);
    n_chk++; if (va !== 5) begin n_fail++; $display("FAIL nom_latency: got cycle %0d expected 5", va); end
    n_chk++; if (vd !== 48'h004003002001) begin n_fail++; $display("FAIL nom_data: got %h expected 004003002001", vd); end
    n_chk++; if (hs_cnt - h0 !== 1) begin n_fail++; $display("FAIL nom_handshakes: got %0d expected 1", hs_cnt - h0); end
    n_chk++; if (frm_valid !== 1'b0) begin n_fail++; $display("FAIL nom_valid_clear: got %b expected 0", frm_valid); end
    n_chk++; if ({sel_err, seq_err, ovf} !== 3'b000) begin n_fail++; $display("FAIL nom_flags: got %b expected 000", {sel_err, seq_err, ovf}); end
  endtask

  task automatic test_settle;
    int va; logic [47:0] vd; int h0;
    h0 = hs_cnt;
    slot(4'b0001, 12'h0A1, 16'h0003, 8, va, vd);
    slot(4'b0010, 12'h0A2, 16'h0010, 8, va, vd);
    slot(4'b0100, 12'h0A3, 16'h0010, 8, va, vd);
    slot(4'b1000, 12'h0A4, 16'h0010, 8, va, vd);
    @(negedge clk);
    n_chk++; if (hs_cnt - h0 !== 0) begin n_fail++; $display("FAIL settle_drop: got %0d frames expected 0", hs_cnt - h0); end
    pass(12'h010, 16'h0004, va, vd);
    n_chk++; if (va !== 3) begin n_fail++; $display("FAIL settle_latency: got cycle %0d expected 3", va); end
    n_chk++; if (vd !== 48'h014013012011) begin n_fail++; $display("FAIL settle_data: got %h expected 014013012011", vd); end
    n_chk++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL settle_seq: got %b expected 0", seq_err); end
  endtask

  task automatic test_duplicate;
    int va; logic [47:0] vd;
    slot(4'b0001, 12'h501, 16'h0028, 8, va, vd);
    slot(4'b0010, 12'h502, 16'h0028, 8, va, vd);
    slot(4'b0100, 12'h503, 16'h0028, 8, va, vd);
    slot(4'b1000, 12'h504, 16'h0008, 8, va, vd);
    n_chk++; if (vd !== 48'h504503502501) begin n_fail++; $display("FAIL dup_data: got %h expected 504503502501", vd); end
    n_chk++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL dup_seq: got %b expected 0", seq_err); end
  endtask

  task automatic test_illegal_sel;
    int va; logic [47:0] vd; int h0;
    h0 = hs_cnt;
    slot(4'b0001, 12'h101, 16'h0010, 8, va, vd);
    slot(4'b0010, 12'h102, 16'h0010, 8, va, vd);
    slot(4'b0011, 12'h0FF, 16'h0010, 8, va, vd);
    n_chk++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL illsel_flag: got %b expected 1", sel_err); end
    slot(4'b0100, 12'h103, 16'h0010, 8, va, vd);
    slot(4'b1000, 12'h104, 16'h0010, 8, va, vd);
    @(negedge clk);
    n_chk++; if (hs_cnt - h0 !== 0) begin n_fail++; $display("FAIL illsel_noframe: got %0d frames expected 0", hs_cnt - h0); end
    pass(12'h110, 16'h0010, va, vd);
    n_chk++; if (vd !== 48'h114113112111) begin n_fail++; $display("FAIL illsel_recover: got %h expected 114113112111", vd); end
    n_chk++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL illsel_seq: got %b expected 0", seq_err); end
  endtask

  task automatic test_order_fault;
    int va; logic [47:0] vd; int h0;
    h0 = hs_cnt;
    slot(4'b0001, 12'h201, 16'h0010, 8, va, vd);
    slot(4'b0010, 12'h202, 16'h0010, 8, va, vd);
    slot(4'b1000, 12'h204, 16'h0010, 8, va, vd);
    @(negedge clk);
    n_chk++; if (seq_err !== 1'b1) begin n_fail++; $display("FAIL order_flag: got %b expected 1", seq_err); end
    n_chk++; if (hs_cnt - h0 !== 0) begin n_fail++; $display("FAIL order_noframe: got %0d frames expected 0", hs_cnt - h0); end
    pass(12'h300, 16'h0010, va, vd);
    n_chk++; if (vd !== 48'h304303302301) begin n_fail++; $display("FAIL order_recover: got %h expected 304303302301", vd); end
  endtask

  task automatic test_backpressure;
    int va; logic [47:0] vd; int h0;
    frm_ready = 1'b0;
    h0 = hs_cnt;
    pass(12'h600, 16'h0010, va, vd);
    n_chk++; if (vd !== 48'h604603602601) begin n_fail++; $display("FAIL bp_first: got %h expected 604603602601", vd); end
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL bp_ovf_early: got %b expected 0", ovf); end
    pass(12'h700, 16'h0010, va, vd);
    @(negedge clk);
    n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL bp_ovf: got %b expected 1", ovf); end
    n_chk++; if (frm_data !== 48'h604603602601) begin n_fail++; $display("FAIL bp_hold: got %h expected 604603602601", frm_data); end
    n_chk++; if (frm_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", frm_valid); end
    frm_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (hs_cnt - h0 !== 1) begin n_fail++; $display("FAIL bp_handshake: got %0d expected 1", hs_cnt - h0); end
    n_chk++; if (frm_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b expected 0", frm_valid); end
  endtask

  task automatic test_async_reset;
    int va; logic [47:0] vd; int h0;
    slot(4'b0001, 12'h801, 16'h0010, 8, va, vd);
    slot(4'b0010, 12'h802, 16'h0010, 8, va, vd);
    @(negedge clk);
    #2 RST = 1'b1;
    #1;
    n_chk++; if ({sel_err, seq_err, ovf} !== 3'b000) begin n_fail++; $display("FAIL arst_flags: got %b expected 000", {sel_err, seq_err, ovf}); end
    n_chk++; if (frm_data !== 48'h0) begin n_fail++; $display("FAIL arst_data: got %h expected 0", frm_data); end
    n_chk++; if (frm_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b expected 0", frm_valid); end
    repeat (2) @(negedge clk);
    #3 RST = 1'b0;
    h0 = hs_cnt;
    slot(4'b0010, 12'h902, 16'h0010, 8, va, vd);
    slot(4'b0100, 12'h903, 16'h0010, 8, va, vd);
    slot(4'b1000, 12'h904, 16'h0010, 8, va, vd);
    @(negedge clk);
    n_chk++; if (hs_cnt - h0 !== 0) begin n_fail++; $display("FAIL arst_noframe: got %0d frames expected 0", hs_cnt - h0); end
    n_chk++; if (seq_err !== 1'b0) begin n_fail++; $display("FAIL arst_seq: got %b expected 0", seq_err); end
    pass(12'hA00, 16'h0010, va, vd);
    n_chk++; if (vd !== 48'hA04A03A02A01) begin n_fail++; $display("FAIL arst_recover: got %h expected a04a03a02a01", vd); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_settle();
    test_duplicate();
    test_illegal_sel();
    test_order_fault();
    test_backpressure();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tdm_frame_collector.md
Name: tdm_frame_collector

Overview:
- ADC-side counterpart of the 4-channel TDM multiplexer controller.
- Takes the one-hot channel selects CH1..CH4 driven to the analog mux, plus the ADC sample stream.
- Discards samples taken during mux settling, tags each valid sample with its channel, and assembles ordered 4-channel frames.
- Presents each frame on a valid/ready interface to the downstream EEG digital path.

Parameters:
- DATA_W, 12, ADC sample width in bits.
- SETTLE_CYC, 2, clk cycles after any select change during which incoming samples are discarded (range 0..15).

Ports:
- clk  input  1  system clock, same domain as the mux controller.
- RST  input  1  asynchronous, active-high reset.
- CH1  input  1  mux select, channel 1.
- CH2  input  1  mux select, channel 2.
- CH3  input  1  mux select, channel 3.
- CH4  input  1  mux select, channel 4.
- smp_valid  input  1  one-cycle strobe; smp_data is valid.
- smp_data  input  DATA_W  ADC sample.
- frm_valid  output  1  frame available.
- frm_ready  input  1  downstream accepts the frame.
- frm_data  output  4*DATA_W  {ch4,ch3,ch2,ch1}; ch1 occupies the LSBs.
- sel_err  output  1  sticky: select vector was not one-hot while smp_valid was high.
- seq_err  output  1  sticky: a channel arrived out of order.
- ovf  output  1  sticky: a frame completed while frm_valid was still high.

Behaviour:
- Interface: reset RST, asynchronous, active-high; clock clk.
- Reset values: frm_valid=0, frm_data=0, sel_err=0, seq_err=0, ovf=0, FSM=SYNC, settle counter=SETTLE_CYC, expected index=0.
- Sticky flags clear only on RST.
- Select tracking:
  - Register {CH4..CH1} every cycle.
  - Any difference from the previous cycle reloads the settle counter to SETTLE_CYC.
  - Otherwise the counter decrements, saturating at 0.
  - A sample is eligible only when the counter is 0 in that cycle.
  - With SETTLE_CYC=0, every sample is eligible.
  - When a select change and smp_valid occur in the same cycle, the sample is ineligible (reload wins).
- Channel decode: one-hot {CH4..CH1} maps to index 0..3 (CH1=0). Zero or multiple bits set with smp_valid=1 sets sel_err; the sample is dropped and the FSM goes to SYNC.
- FSM:
  - SYNC: wait for an eligible CH1 sample. Store it in slot 0, set expected=1, go to COLLECT. Eligible samples on other channels are dropped silently.
  - COLLECT, eligible sample with index==expected: store in slot[index]. If index==3, the frame is complete and the FSM returns to SYNC with expected=0. Otherwise expected+=1.
  - COLLECT, eligible sample with index!=expected: set seq_err and discard the partial frame.
    - If the sample is CH1, restart: slot0 stored, expected=1, stay in COLLECT.
    - Otherwise go to SYNC.
  - Multiple eligible samples on the same channel without a change: the first is stored and later ones are dropped. This is not an error; the sample counts as index≠expected only when its index differs from expected.
- Frame output:
  - On completion, if frm_valid=0 or (frm_valid & frm_ready) in the same cycle, load frm_data from the 4 slots (slot 3 taken from the current sample) and set frm_valid=1 on the next edge.
  - Latency: CH4 sample cycle to frm_valid high is 1 clk.
  - Otherwise set ovf and drop the new frame; held frm_data remains unchanged.
  - frm_valid clears on frm_valid & frm_ready when there is no simultaneous load.
  - frm_data is stable while frm_valid=1 and frm_ready=0.
- Reset mid-frame: all state, including partial slots and the pending frame, is discarded immediately.

Decomposition:
- Package tdm_pkg:
  - NUM_CH=4.
  - Channel index typedef (2-bit).
  - FSM state enum {SYNC, COLLECT}.
  - Function onehot_to_idx returning index plus a valid bit.
- Sub-module tdm_settle_gate: select register, change detect, settle counter, and the eligible output.

Test Plan:
- Nominal: drive the controller sequence CH4,CH1,CH2,CH3,CH4, each held 8 clk with SETTLE_CYC=2 and one smp_valid at cycle 4 of each slot (data 0x004,0x001,0x002,0x003,0x004), frm_ready=1 -> one frm_valid pulse 1 clk after the CH4 sample with frm_data={0x004,0x003,0x002,0x001}. The leading CH4 sample is dropped and no flags are set.
- Settle: smp_valid on the cycle of a select change and 1 clk after -> both samples dropped and no frame. A sample 2 clk after the change is captured.
- Illegal select: CH1=CH2=1 with smp_valid -> sel_err=1, FSM returns to SYNC, and the next full CH1..CH4 pass yields a correct frame.
- Order fault: CH1, CH2, then CH4 -> seq_err=1, no frame; the following CH1..CH4 pass produces a frame.
- Backpressure: frm_ready=0 across two complete passes -> first frame held unchanged, ovf=1 after the second. Raising frm_ready gives one handshake, then frm_valid=0.
- Async reset asserted mid-COLLECT between clk edges -> all outputs read 0 immediately. After release, a CH2..CH4 pass produces no frame until CH1 arrives.
